control_sequencer: RTL and testbench

Hardwired control unit that sits directly upstream of `datapath`. It steps through the fetch/decode/execute T-states and drives every register-transfer strobe that benches currently toggle by hand. It reads the opcode from the datapath's IR and sequences one instruction at a time, with one T-state per clock. It supports register-register ALU ops, immediates, negate/not, load/store, nop and halt.

---
 rtl/control_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the datapath: one T-state per clock,
// Moore outputs decoded from the state register and the IR opcode.
module control_sequencer #(
  parameter int MEM_WAIT = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZLowOut,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [4:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_WAIT, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RR, C_IMM, C_UNARY, C_LD, C_LDI, C_ST, C_NOP, C_HALT, C_ILLEGAL
  } op_class_t;

  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [1:0] WAIT_LOAD = (MEM_WAIT > 0) ? 2'(MEM_WAIT - 1) : 2'd0;

  state_t     state;
  state_t     wait_ret;
  logic [1:0] wait_cnt;
  logic [4:0] opcode;
  op_class_t  op_class;

  assign opcode = ir[31:27];

  // Only the opcode field steers sequencing; operand fields belong to the datapath.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[26:0];

  function automatic op_class_t decode_op(input logic [4:0] op);
    if (op inside {[5'b00011:5'b01011]})      return C_RR;
    else if (op inside {[5'b01100:5'b01110]}) return C_IMM;
    else if (op inside {5'b10001, 5'b10010})  return C_UNARY;
    else if (op == 5'b00000)                  return C_LD;
    else if (op == 5'b00001)                  return C_LDI;
    else if (op == 5'b00010)                  return C_ST;
    else if (op == 5'b11010)                  return C_NOP;
    else if (op == 5'b11011)                  return C_HALT;
    else                                      return C_ILLEGAL;
  endfunction

  assign op_class = decode_op(opcode);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= S_RESET;
      wait_cnt <= 2'd0;
      wait_ret <= S_T2;
    end else begin
      unique case (state)
        S_RESET: state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1: begin
          if (MEM_WAIT > 0) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_LOAD;
            wait_ret <= S_T2;
          end else begin
            state <= S_T2;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 2'd0) state <= wait_ret;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        S_T2: begin
          unique case (op_class)
            C_NOP:             state <= stop ? S_HALT : S_T0;
            C_HALT, C_ILLEGAL: state <= S_HALT;
            default:           state <= S_T3;
          endcase
        end
        S_T3: state <= S_T4;
        S_T4: begin
          if (op_class == C_UNARY) state <= stop ? S_HALT : S_T0;
          else                     state <= S_T5;
        end
        S_T5: begin
          if (op_class inside {C_LD, C_ST}) state <= S_T6;
          else                              state <= stop ? S_HALT : S_T0;
        end
        S_T6: begin
          // Only a load reads memory here; a store drives MDR from the bus.
          if (MEM_WAIT > 0 && op_class == C_LD) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_LOAD;
            wait_ret <= S_T7;
          end else begin
            state <= S_T7;
          end
        end
        S_T7:   state <= stop ? S_HALT : S_T0;
        S_HALT: state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; Read = 1'b0; Write = 1'b0; IRin = 1'b0; Yin = 1'b0;
    ZLowIn = 1'b0; ZLowOut = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
    alu_op = 5'b00000;
    run    = 1'b1;

    unique case (state)
      S_RESET: ;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
      end
      S_T1: begin
        ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_WAIT: begin
        Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        Grb = 1'b1;
        unique case (op_class)
          C_RR, C_IMM: begin Rout = 1'b1; Yin = 1'b1; end
          C_UNARY:     begin Rout = 1'b1; ZLowIn = 1'b1; alu_op = opcode; end
          C_LD, C_LDI, C_ST: begin BAout = 1'b1; Yin = 1'b1; end
          default: Grb = 1'b0;
        endcase
      end
      S_T4: begin
        unique case (op_class)
          C_RR:    begin Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; alu_op = opcode; end
          C_IMM:   begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = opcode; end
          C_UNARY: begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_LDI, C_ST: begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = ALU_ADD; end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (op_class)
          C_RR, C_IMM, C_LDI: begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST:         begin ZLowOut = 1'b1; MARin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        if (op_class == C_LD) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (op_class == C_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (op_class == C_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (op_class == C_ST) begin
          Write = 1'b1;
        end
      end
      S_HALT: run = 1'b0;
      default: run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle strobe vectors are queued
// as each instruction is issued and compared one per clock against the DUT.
module tb_control_sequencer;

  localparam logic [24:0] M_PCOUT   = 25'h0000001, M_PCIN   = 25'h0000002,
                          M_INCPC   = 25'h0000004, M_MARIN  = 25'h0000008,
                          M_MDRIN   = 25'h0000010, M_MDROUT = 25'h0000020,
                          M_READ    = 25'h0000040, M_WRITE  = 25'h0000080,
                          M_IRIN    = 25'h0000100, M_YIN    = 25'h0000200,
                          M_ZLOWIN  = 25'h0000400, M_ZLOWOUT = 25'h0000800,
                          M_GRA     = 25'h0001000, M_GRB    = 25'h0002000,
                          M_GRC     = 25'h0004000, M_RIN    = 25'h0008000,
                          M_ROUT    = 25'h0010000, M_BAOUT  = 25'h0020000,
                          M_COUT    = 25'h0040000, M_RUN    = 25'h0080000;

  localparam logic [24:0] V_RESET = M_RUN;
  localparam logic [24:0] V_HALT  = 25'h0;
  localparam logic [24:0] V_T0    = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
  localparam logic [24:0] V_T1    = M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [24:0] V_WAIT  = M_RUN | M_READ | M_MDRIN;
  localparam logic [24:0] V_T2    = M_RUN | M_MDROUT | M_IRIN;
  localparam logic [24:0] V_WB    = M_RUN | M_ZLOWOUT | M_GRA | M_RIN;

  logic        clock = 1'b0;
  logic        clear0 = 1'b1, clear2 = 1'b1;
  logic        stop0 = 1'b0, stop2 = 1'b0;
  logic [31:0] ir0 = 32'h0, ir2 = 32'h0;
  logic [18:0] s0, s2;
  logic [4:0]  a0, a2;
  logic        r0, r2;
  logic [24:0] obs0, obs2;

  logic [24:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  string       tag;

  always #5 clock = ~clock;

  control_sequencer #(.MEM_WAIT(0)) dut0 (
    .clock(clock), .clear(clear0), .ir(ir0), .stop(stop0),
    .PCout(s0[0]), .PCin(s0[1]), .IncPC(s0[2]), .MARin(s0[3]), .MDRin(s0[4]),
    .MDRout(s0[5]), .Read(s0[6]), .Write(s0[7]), .IRin(s0[8]), .Yin(s0[9]),
    .ZLowIn(s0[10]), .ZLowOut(s0[11]), .Gra(s0[12]), .Grb(s0[13]), .Grc(s0[14]),
    .Rin(s0[15]), .Rout(s0[16]), .BAout(s0[17]), .Cout(s0[18]),
    .alu_op(a0), .run(r0)
  );

  control_sequencer #(.MEM_WAIT(2)) dut2 (
    .clock(clock), .clear(clear2), .ir(ir2), .stop(stop2),
    .PCout(s2[0]), .PCin(s2[1]), .IncPC(s2[2]), .MARin(s2[3]), .MDRin(s2[4]),
    .MDRout(s2[5]), .Read(s2[6]), .Write(s2[7]), .IRin(s2[8]), .Yin(s2[9]),
    .ZLowIn(s2[10]), .ZLowOut(s2[11]), .Gra(s2[12]), .Grb(s2[13]), .Grc(s2[14]),
    .Rin(s2[15]), .Rout(s2[16]), .BAout(s2[17]), .Cout(s2[18]),
    .alu_op(a2), .run(r2)
  );

  assign obs0 = {a0, r0, s0};
  assign obs2 = {a2, r2, s2};

  function automatic logic [24:0] alu(input logic [4:0] op);
    return {op, 20'h0};
  endfunction

  // Expected vectors for one instruction, straight from the T-state tables.
  task automatic push_instr(input logic [4:0] op, input int waits);
    exp_q.push_back(V_T0);
    exp_q.push_back(V_T1);
    for (int i = 0; i < waits; i++) exp_q.push_back(V_WAIT);
    exp_q.push_back(V_T2);
    if (op >= 5'd3 && op <= 5'd11) begin
      exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
      exp_q.push_back(M_RUN | M_GRC | M_ROUT | M_ZLOWIN | alu(op));
      exp_q.push_back(V_WB);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
      exp_q.push_back(M_RUN | M_COUT | M_ZLOWIN | alu(op));
      exp_q.push_back(V_WB);
    end else if (op == 5'd17 || op == 5'd18) begin
      exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_ZLOWIN | alu(op));
      exp_q.push_back(V_WB);
    end else if (op <= 5'd2) begin
      exp_q.push_back(M_RUN | M_GRB | M_BAOUT | M_YIN);
      exp_q.push_back(M_RUN | M_COUT | M_ZLOWIN | alu(5'b00011));
      if (op == 5'd1) begin
        exp_q.push_back(V_WB);
      end else begin
        exp_q.push_back(M_RUN | M_ZLOWOUT | M_MARIN);
        if (op == 5'd0) begin
          exp_q.push_back(M_RUN | M_READ | M_MDRIN);
          for (int i = 0; i < waits; i++) exp_q.push_back(V_WAIT);
          exp_q.push_back(M_RUN | M_MDROUT | M_GRA | M_RIN);
        end else begin
          exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_MDRIN);
          exp_q.push_back(M_RUN | M_WRITE);
        end
      end
    end
  endtask

  task automatic check_step(input bit sel, input int k);
    logic [24:0] expv, obsv;
    @(posedge clock);
    #1;
    expv = exp_q.pop_front();
    obsv = sel ? obs2 : obs0;
    n_checks++;
    assert (obsv === expv) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %h expected %h", tag, k, obsv, expv);
    end
  endtask

  // Issue one instruction; ir changes only once T0 is showing, so the previous
  // instruction's final state still sees its own opcode.
  task automatic drive_instr(input bit sel, input string name, input logic [31:0] v,
                             input int waits, input int stop_on, input int stop_off,
                             input int clear_at, input int halt_cycles);
    int k;
    tag = name;
    push_instr(v[31:27], waits);
    for (int i = 0; i < halt_cycles; i++) exp_q.push_back(V_HALT);
    k = 0;
    while (exp_q.size() > 0) begin
      check_step(sel, k);
      if (k == 0) begin
        if (sel) ir2 = v; else ir0 = v;
      end
      if (sel) stop2 = (k >= stop_on && k < stop_off);
      else     stop0 = (k >= stop_on && k < stop_off);
      if (k == clear_at) begin
        if (sel) clear2 = 1'b1; else clear0 = 1'b1;
        exp_q.delete();
        exp_q.push_back(V_RESET);
      end
      k++;
    end
  endtask

  task automatic reset_pulse(input bit sel, input string name, input int cycles);
    tag = name;
    if (sel) clear2 = 1'b1; else clear0 = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back(V_RESET);
      check_step(sel, i);
    end
    if (sel) clear2 = 1'b0; else clear0 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    reset_pulse(0, "reset", 2);

    drive_instr(0, "neg",  32'h8A2B8000, 0, -1, -1, -1, 0);
    drive_instr(0, "add",  32'h18000000, 0, -1, -1, -1, 0);
    drive_instr(0, "ld",   32'h00000000, 0, -1, -1, -1, 0);
    drive_instr(0, "st",   32'h10000000, 0, -1, -1, -1, 0);
    drive_instr(0, "addi", 32'h60000000, 0, -1, -1, -1, 0);
    drive_instr(0, "not",  32'h90000000, 0, -1, -1, -1, 0);
    drive_instr(0, "ldi",  32'h08000000, 0, -1, -1, -1, 0);
    drive_instr(0, "shl",  32'h58000000, 0, -1, -1, -1, 0);
    drive_instr(0, "nop",  32'hD0000000, 0, -1, -1, -1, 0);

    // stop seen only in T3 is ignored; stop still high in T5 halts
    drive_instr(0, "add_stop_pulse", 32'h18000000, 0, 3, 4, -1, 0);
    drive_instr(0, "add_stop_held",  32'h18000000, 0, 3, 6, -1, 3);
    stop0 = 1'b0;
    reset_pulse(0, "reset_after_stop", 1);

    // clear in T4 of ld abandons it; the next instruction starts cleanly
    drive_instr(0, "ld_clear", 32'h00000000, 0, -1, -1, 4, 0);
    clear0 = 1'b0;
    drive_instr(0, "nop_after_clear", 32'hD0000000, 0, -1, -1, -1, 0);

    drive_instr(0, "halt", 32'hD8000000, 0, -1, -1, -1, 20);
    reset_pulse(0, "reset_after_halt", 1);
    drive_instr(0, "illegal", 32'hF8000000, 0, -1, -1, -1, 20);
    reset_pulse(0, "reset_after_illegal", 1);
    drive_instr(0, "add_after_recover", 32'h18000000, 0, -1, -1, -1, 0);

    reset_pulse(1, "reset_w2", 1);
    drive_instr(1, "add_w2", 32'h18000000, 2, -1, -1, -1, 0);
    drive_instr(1, "ld_w2",  32'h00000000, 2, -1, -1, -1, 0);
    drive_instr(1, "st_w2",  32'h10000000, 2, -1, -1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
